// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl
// -------------
// Multicycle control unit for the RV32I-subset datapath. A registered state
// machine walks each instruction through fetch, decode, execute, memory and
// write-back, and drives every datapath mux select, register load and write
// enable. Supports an optional memory-ready handshake, optional blt/bge,
// jal, a HALT state and a sticky illegal-instruction trap.
//
// Parameters
//   MEM_HS      1: memory states wait on mem_ready_i; 0: every access is one cycle
//   EXT_BRANCH  1: blt (funct3 100) and bge (funct3 101) are legal
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   instr_i[31:0]         IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25])
//   alu_zero_i, alu_lt_i  ALU flags (result == 0, signed A < B)
//   mem_ready_i           memory access completes this cycle
//   pc_write_o, pc_src_o  PC load enable / source (0 ALU result, 1 ALUOut)
//   ir_load_o             IR load enable
//   mem_read_o, mem_write_o, mem_addr_sel_o   memory request and address select
//   reg_a_load_o, reg_b_load_o, alu_out_load_o, mdr_load_o   register loads
//   reg_write_o, wb_sel_o[1:0]                register-file write and source
//   alu_src_a_o[1:0], alu_src_b_o[1:0], alu_op_o[2:0]        ALU controls
//   state_out_o[3:0]      current state encoding
//   illegal_o, halted_o   trap flag (sticky until rst), halted in HALT/TRAP
//
// Memory handshake: a request (mem_read_o / mem_write_o) is held, with all
// other outputs stable, until mem_ready_i is seen high in the same cycle; the
// access completes on that clock edge and the gated enables (ir_load_o,
// pc_write_o in FETCH, mdr_load_o) fire only in that cycle. With MEM_HS=0 the
// memory is treated as always ready and mem_ready_i is ignored.

module riscv_mc_ctrl #(
    parameter int MEM_HS     = 1,
    parameter int EXT_BRANCH = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        alu_zero_i,
    input  logic        alu_lt_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        ir_load_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        mem_addr_sel_o,
    output logic        reg_a_load_o,
    output logic        reg_b_load_o,
    output logic        alu_out_load_o,
    output logic        mdr_load_o,
    output logic        reg_write_o,
    output logic [1:0]  wb_sel_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic [3:0]  state_out_o,
    output logic        illegal_o,
    output logic        halted_o
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_LUI    = 4'd11,
        S_JAL    = 4'd12,
        S_HALT   = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_HALT   = 7'b0000000;

    localparam bit HS_EN  = (MEM_HS != 0);
    localparam bit EXT_EN = (EXT_BRANCH != 0);

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       ready;
    logic       br_legal;
    logic       br_taken;
    logic       unused_instr;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register specifiers and immediates are the datapath's business.
    assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

    assign ready = !HS_EN || mem_ready_i;

    always_comb begin
        br_legal = 1'b0;
        br_taken = 1'b0;
        case (funct3)
            3'b000: begin br_legal = 1'b1;   br_taken = alu_zero_i;  end
            3'b001: begin br_legal = 1'b1;   br_taken = !alu_zero_i; end
            3'b100: begin br_legal = EXT_EN; br_taken = alu_lt_i;    end
            3'b101: begin br_legal = EXT_EN; br_taken = !alu_lt_i;   end
            default: begin br_legal = 1'b0;  br_taken = 1'b0;        end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_write_o     = 1'b0;
        pc_src_o       = 1'b0;
        ir_load_o      = 1'b0;
        mem_read_o     = 1'b0;
        mem_write_o    = 1'b0;
        mem_addr_sel_o = 1'b0;
        reg_a_load_o   = 1'b0;
        reg_b_load_o   = 1'b0;
        alu_out_load_o = 1'b0;
        mdr_load_o     = 1'b0;
        reg_write_o    = 1'b0;
        wb_sel_o       = 2'd0;
        alu_src_a_o    = 2'd0;
        alu_src_b_o    = 2'd0;
        alu_op_o       = ALU_PASS;
        illegal_o      = 1'b0;
        halted_o       = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // ALU computes PC+4 while memory returns the instruction.
                mem_read_o  = 1'b1;
                alu_src_a_o = 2'd0;
                alu_src_b_o = 2'd1;
                alu_op_o    = ALU_ADD;
                if (ready) begin
                    ir_load_o  = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculatively form old PC + B/J-immediate as the jump target.
                reg_a_load_o   = 1'b1;
                reg_b_load_o   = 1'b1;
                alu_src_a_o    = 2'd2;
                alu_src_b_o    = 2'd3;
                alu_op_o       = ALU_ADD;
                alu_out_load_o = 1'b1;
                case (opcode)
                    OP_R:      state_d = S_EXEC_R;
                    OP_I:      state_d = (funct3 == 3'b000) ? S_EXEC_I : S_TRAP;
                    OP_LOAD:   state_d = S_ADDR;
                    OP_STORE:  state_d = S_ADDR;
                    OP_BRANCH: state_d = br_legal ? S_BRANCH : S_TRAP;
                    OP_LUI:    state_d = S_LUI;
                    OP_JAL:    state_d = S_JAL;
                    OP_HALT:   state_d = S_HALT;
                    default:   state_d = S_TRAP;
                endcase
            end

            S_EXEC_R: begin
                alu_src_a_o    = 2'd1;
                alu_src_b_o    = 2'd0;
                alu_out_load_o = 1'b1;
                state_d        = S_WB_ALU;
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    alu_op_o = ALU_ADD;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    alu_op_o = ALU_SUB;
                end else if (funct3 == 3'b111) begin
                    alu_op_o = ALU_AND;
                end else if (funct3 == 3'b110) begin
                    alu_op_o = ALU_OR;
                end else begin
                    state_d = S_TRAP;
                end
            end

            S_EXEC_I: begin
                alu_src_a_o    = 2'd1;
                alu_src_b_o    = 2'd2;
                alu_op_o       = ALU_ADD;
                alu_out_load_o = 1'b1;
                state_d        = S_WB_ALU;
            end

            S_ADDR: begin
                alu_src_a_o    = 2'd1;
                alu_src_b_o    = 2'd2;
                alu_op_o       = ALU_ADD;
                alu_out_load_o = 1'b1;
                state_d        = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                mem_read_o     = 1'b1;
                mem_addr_sel_o = 1'b1;
                if (ready) begin
                    mdr_load_o = 1'b1;
                    state_d    = S_WB_MEM;
                end
            end

            S_MEM_WR: begin
                mem_write_o    = 1'b1;
                mem_addr_sel_o = 1'b1;
                if (ready) begin
                    state_d = S_FETCH;
                end
            end

            S_WB_ALU: begin
                reg_write_o = 1'b1;
                wb_sel_o    = 2'd0;
                state_d     = S_FETCH;
            end

            S_WB_MEM: begin
                reg_write_o = 1'b1;
                wb_sel_o    = 2'd1;
                state_d     = S_FETCH;
            end

            S_BRANCH: begin
                // ALUOut already holds the target computed in DECODE.
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd0;
                alu_op_o    = ALU_SUB;
                pc_src_o    = 1'b1;
                pc_write_o  = br_taken;
                state_d     = S_FETCH;
            end

            S_LUI: begin
                reg_write_o = 1'b1;
                wb_sel_o    = 2'd3;
                state_d     = S_FETCH;
            end

            S_JAL: begin
                // PC was already advanced in FETCH, so it is the link value.
                reg_write_o = 1'b1;
                wb_sel_o    = 2'd2;
                pc_write_o  = 1'b1;
                pc_src_o    = 1'b1;
                state_d     = S_FETCH;
            end

            S_HALT: begin
                halted_o = 1'b1;
            end

            S_TRAP: begin
                illegal_o = 1'b1;
                halted_o  = 1'b1;
            end

            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign state_out_o = state_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl. Two instances share the instruction and
// flag inputs: dut_a (MEM_HS=1, EXT_BRANCH=0) and dut_b (MEM_HS=0,
// EXT_BRANCH=1). The instance not under test is held in reset.
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_riscv_mc_ctrl;

    logic        clk;
    logic        rst_a, rst_b;
    logic [31:0] instr;
    logic        alu_zero, alu_lt, mem_ready;

    logic        pc_write_a, pc_src_a, ir_load_a, mem_read_a, mem_write_a, mem_addr_sel_a;
    logic        reg_a_load_a, reg_b_load_a, alu_out_load_a, mdr_load_a, reg_write_a;
    logic [1:0]  wb_sel_a, alu_src_a_a, alu_src_b_a;
    logic [2:0]  alu_op_a;
    logic [3:0]  state_a;
    logic        illegal_a, halted_a;

    logic        pc_write_b, pc_src_b, ir_load_b, mem_read_b, mem_write_b, mem_addr_sel_b;
    logic        reg_a_load_b, reg_b_load_b, alu_out_load_b, mdr_load_b, reg_write_b;
    logic [1:0]  wb_sel_b, alu_src_a_b, alu_src_b_b;
    logic [2:0]  alu_op_b;
    logic [3:0]  state_b;
    logic        illegal_b, halted_b;

    logic [25:0] vec_a, vec_b;

    int n_cmp = 0;
    int n_err = 0;

    assign vec_a = {state_a, pc_write_a, pc_src_a, ir_load_a, mem_read_a, mem_write_a,
                    mem_addr_sel_a, reg_a_load_a, reg_b_load_a, alu_out_load_a, mdr_load_a,
                    reg_write_a, wb_sel_a, alu_src_a_a, alu_src_b_a, alu_op_a, illegal_a,
                    halted_a};
    assign vec_b = {state_b, pc_write_b, pc_src_b, ir_load_b, mem_read_b, mem_write_b,
                    mem_addr_sel_b, reg_a_load_b, reg_b_load_b, alu_out_load_b, mdr_load_b,
                    reg_write_b, wb_sel_b, alu_src_a_b, alu_src_b_b, alu_op_b, illegal_b,
                    halted_b};

    riscv_mc_ctrl #(.MEM_HS(1), .EXT_BRANCH(0)) dut_a (
        .clk(clk), .rst(rst_a), .instr_i(instr), .alu_zero_i(alu_zero), .alu_lt_i(alu_lt),
        .mem_ready_i(mem_ready), .pc_write_o(pc_write_a), .pc_src_o(pc_src_a),
        .ir_load_o(ir_load_a), .mem_read_o(mem_read_a), .mem_write_o(mem_write_a),
        .mem_addr_sel_o(mem_addr_sel_a), .reg_a_load_o(reg_a_load_a),
        .reg_b_load_o(reg_b_load_a), .alu_out_load_o(alu_out_load_a),
        .mdr_load_o(mdr_load_a), .reg_write_o(reg_write_a), .wb_sel_o(wb_sel_a),
        .alu_src_a_o(alu_src_a_a), .alu_src_b_o(alu_src_b_a), .alu_op_o(alu_op_a),
        .state_out_o(state_a), .illegal_o(illegal_a), .halted_o(halted_a)
    );

    riscv_mc_ctrl #(.MEM_HS(0), .EXT_BRANCH(1)) dut_b (
        .clk(clk), .rst(rst_b), .instr_i(instr), .alu_zero_i(alu_zero), .alu_lt_i(alu_lt),
        .mem_ready_i(mem_ready), .pc_write_o(pc_write_b), .pc_src_o(pc_src_b),
        .ir_load_o(ir_load_b), .mem_read_o(mem_read_b), .mem_write_o(mem_write_b),
        .mem_addr_sel_o(mem_addr_sel_b), .reg_a_load_o(reg_a_load_b),
        .reg_b_load_o(reg_b_load_b), .alu_out_load_o(alu_out_load_b),
        .mdr_load_o(mdr_load_b), .reg_write_o(reg_write_b), .wb_sel_o(wb_sel_b),
        .alu_src_a_o(alu_src_a_b), .alu_src_b_o(alu_src_b_b), .alu_op_o(alu_op_b),
        .state_out_o(state_b), .illegal_o(illegal_b), .halted_o(halted_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    // Driver tasks: release one instance from reset; on return the instance
    // sits in RESET and enters FETCH on the next rising edge.
    task automatic start_a();
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic start_b();
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        instr     = 32'h002081B3;
        mem_ready = 1'b1;
        alu_zero  = 1'b1;
        alu_lt    = 1'b1;
        #1;
        n_cmp++;
        if (vec_a !== 26'd0) begin
            n_err++;
            $display("FAIL reset_outs_a got %h want 0", vec_a);
        end
        n_cmp++;
        if (vec_b !== 26'd0) begin
            n_err++;
            $display("FAIL reset_outs_b got %h want 0", vec_b);
        end
    endtask

    // add x3,x1,x2 with MEM_HS=0: states 0,1,2,3,8,1
    task automatic test_add();
        logic [3:0] exp_st [5] = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd1};
        logic       exp_rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_ir [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        instr     = 32'h002081B3;
        mem_ready = 1'b0;
        start_b();
        #1;
        n_cmp++;
        if (vec_b !== 26'd0) begin
            n_err++;
            $display("FAIL add_reset_state got %h want 0", vec_b);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            n_cmp++;
            if (state_b !== exp_st[i]) begin
                n_err++;
                $display("FAIL add_state[%0d] got %0d want %0d", i, state_b, exp_st[i]);
            end
            n_cmp++;
            if (reg_write_b !== exp_rw[i]) begin
                n_err++;
                $display("FAIL add_reg_write[%0d] got %b want %b", i, reg_write_b, exp_rw[i]);
            end
            n_cmp++;
            if (ir_load_b !== exp_ir[i] || pc_write_b !== exp_ir[i]) begin
                n_err++;
                $display("FAIL add_ir_pc[%0d] got %b%b want %b%b", i, ir_load_b, pc_write_b,
                         exp_ir[i], exp_ir[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if (alu_op_b !== 3'd1 || alu_src_a_b !== 2'd1 || alu_src_b_b !== 2'd0) begin
                    n_err++;
                    $display("FAIL add_exec_alu got op%0d a%0d b%0d want op1 a1 b0",
                             alu_op_b, alu_src_a_b, alu_src_b_b);
                end
            end
        end
    endtask

    // lw with a fetch wait and two MEM_RD wait cycles (MEM_HS=1)
    task automatic test_load();
        logic       mr      [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp_st  [9] = '{4'd1, 4'd1, 4'd2, 4'd5, 4'd6, 4'd6, 4'd6, 4'd9, 4'd1};
        logic       exp_mdr [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       exp_ir  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_rd  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       exp_rw  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        instr = 32'h0040A183;
        start_a();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            mem_ready = mr[i];
            #1;
            n_cmp++;
            if (state_a !== exp_st[i]) begin
                n_err++;
                $display("FAIL lw_state[%0d] got %0d want %0d", i, state_a, exp_st[i]);
            end
            n_cmp++;
            if (mdr_load_a !== exp_mdr[i] || ir_load_a !== exp_ir[i] ||
                mem_read_a !== exp_rd[i] || reg_write_a !== exp_rw[i]) begin
                n_err++;
                $display("FAIL lw_enables[%0d] got mdr%b ir%b rd%b rw%b want mdr%b ir%b rd%b rw%b",
                         i, mdr_load_a, ir_load_a, mem_read_a, reg_write_a,
                         exp_mdr[i], exp_ir[i], exp_rd[i], exp_rw[i]);
            end
            if (i == 7) begin
                n_cmp++;
                if (wb_sel_a !== 2'd1) begin
                    n_err++;
                    $display("FAIL lw_wb_sel got %0d want 1", wb_sel_a);
                end
            end
        end
    endtask

    // Branch decisions on dut_b (EXT_BRANCH=1)
    task automatic test_branch();
        logic [31:0] br_ins [7] = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h0020C463,
                                     32'h0020C463, 32'h0020D463, 32'h0020D463};
        logic        br_z   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        br_lt  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        br_tk  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 7; t++) begin
            instr    = br_ins[t];
            alu_zero = br_z[t];
            alu_lt   = br_lt[t];
            start_b();
            @(negedge clk);
            @(negedge clk);
            #1;
            n_cmp++;
            if (alu_out_load_b !== 1'b1 || alu_src_a_b !== 2'd2 || alu_src_b_b !== 2'd3) begin
                n_err++;
                $display("FAIL br_decode[%0d] got ld%b a%0d b%0d want ld1 a2 b3", t,
                         alu_out_load_b, alu_src_a_b, alu_src_b_b);
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if (state_b !== 4'd10 || pc_write_b !== br_tk[t] || pc_src_b !== 1'b1 ||
                alu_op_b !== 3'd2) begin
                n_err++;
                $display("FAIL br_exec[%0d] got st%0d pcw%b src%b op%0d want st10 pcw%b src1 op2",
                         t, state_b, pc_write_b, pc_src_b, alu_op_b, br_tk[t]);
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if (state_b !== 4'd1) begin
                n_err++;
                $display("FAIL br_return[%0d] got %0d want 1", t, state_b);
            end
        end
        alu_zero = 1'b0;
        alu_lt   = 1'b0;
    endtask

    // blt on dut_a (EXT_BRANCH=0) traps and the flag sticks
    task automatic test_trap();
        instr = 32'h0020C463;
        start_a();
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (state_a !== 4'd14 || illegal_a !== 1'b1 || halted_a !== 1'b1) begin
            n_err++;
            $display("FAIL trap_enter got st%0d ill%b halt%b want st14 ill1 halt1",
                     state_a, illegal_a, halted_a);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ready = i[0];
            alu_lt    = i[1];
            instr     = (i[0]) ? 32'h002081B3 : 32'h00000000;
            #1;
            n_cmp++;
            if (illegal_a !== 1'b1 || state_a !== 4'd14 || pc_write_a !== 1'b0 ||
                reg_write_a !== 1'b0) begin
                n_err++;
                $display("FAIL trap_sticky[%0d] got st%0d ill%b pcw%b rw%b want st14 ill1 pcw0 rw0",
                         i, state_a, illegal_a, pc_write_a, reg_write_a);
            end
        end
    endtask

    // Unsupported R-type funct3 (sll) traps from EXEC_R
    task automatic test_illegal_r();
        logic [3:0] exp_st [4] = '{4'd1, 4'd2, 4'd3, 4'd14};
        instr = 32'h002091B3;
        start_b();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (state_b !== exp_st[i] || reg_write_b !== 1'b0) begin
                n_err++;
                $display("FAIL sll_state[%0d] got st%0d rw%b want st%0d rw0", i, state_b,
                         reg_write_b, exp_st[i]);
            end
        end
        n_cmp++;
        if (illegal_b !== 1'b1) begin
            n_err++;
            $display("FAIL sll_illegal got %b want 1", illegal_b);
        end
    endtask

    // lui and jal: three-cycle instructions
    task automatic test_uj();
        logic [31:0] ins   [2] = '{32'h123450B7, 32'h008000EF};
        logic [3:0]  st    [2] = '{4'd11, 4'd12};
        logic [1:0]  wb    [2] = '{2'd3, 2'd2};
        logic        pcw   [2] = '{1'b0, 1'b1};
        for (int t = 0; t < 2; t++) begin
            instr = ins[t];
            start_b();
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            #1;
            n_cmp++;
            if (state_b !== st[t] || reg_write_b !== 1'b1 || wb_sel_b !== wb[t] ||
                pc_write_b !== pcw[t] || pc_src_b !== pcw[t]) begin
                n_err++;
                $display("FAIL uj[%0d] got st%0d rw%b wb%0d pcw%b src%b want st%0d rw1 wb%0d pcw%b src%b",
                         t, state_b, reg_write_b, wb_sel_b, pc_write_b, pc_src_b,
                         st[t], wb[t], pcw[t], pcw[t]);
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if (state_b !== 4'd1) begin
                n_err++;
                $display("FAIL uj_return[%0d] got %0d want 1", t, state_b);
            end
        end
    endtask

    // sw with MEM_HS=0 ignores a low mem_ready: four cycles
    task automatic test_store_nohs();
        logic [3:0] exp_st [5] = '{4'd1, 4'd2, 4'd5, 4'd7, 4'd1};
        logic       exp_wr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        instr     = 32'h0020A223;
        mem_ready = 1'b0;
        start_b();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (state_b !== exp_st[i] || mem_write_b !== exp_wr[i] ||
                mem_addr_sel_b !== exp_wr[i]) begin
                n_err++;
                $display("FAIL sw_nohs[%0d] got st%0d wr%b as%b want st%0d wr%b as%b", i,
                         state_b, mem_write_b, mem_addr_sel_b, exp_st[i], exp_wr[i], exp_wr[i]);
            end
        end
    endtask

    // Opcode 0 halts; reset clears everything immediately
    task automatic test_halt();
        instr = 32'h00000000;
        start_b();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (state_b !== 4'd13 || halted_b !== 1'b1 || illegal_b !== 1'b0) begin
                n_err++;
                $display("FAIL halt[%0d] got st%0d halt%b ill%b want st13 halt1 ill0", i,
                         state_b, halted_b, illegal_b);
            end
        end
        #2;
        rst_b = 1'b1;
        #1;
        n_cmp++;
        if (vec_b !== 26'd0) begin
            n_err++;
            $display("FAIL halt_reset got %h want 0", vec_b);
        end
    endtask

    // Reset asserted mid-MEM_WR: mem_write drops at once, FETCH one cycle after release
    task automatic test_rst_mid_wr();
        instr = 32'h0020A223;
        start_a();
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (state_a !== 4'd7 || mem_write_a !== 1'b1) begin
            n_err++;
            $display("FAIL wr_wait got st%0d wr%b want st7 wr1", state_a, mem_write_a);
        end
        #1;
        rst_a = 1'b1;
        #1;
        n_cmp++;
        if (mem_write_a !== 1'b0 || vec_a !== 26'd0) begin
            n_err++;
            $display("FAIL wr_rst_drop got wr%b outs %h want wr0 outs 0", mem_write_a, vec_a);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        rst_a = 1'b0;
        #1;
        n_cmp++;
        if (state_a !== 4'd0) begin
            n_err++;
            $display("FAIL wr_rst_hold got %0d want 0", state_a);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (state_a !== 4'd1) begin
            n_err++;
            $display("FAIL wr_rst_fetch got %0d want 1", state_a);
        end
    endtask

    initial begin
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        instr     = 32'h0;
        alu_zero  = 1'b0;
        alu_lt    = 1'b0;
        mem_ready = 1'b0;

        test_reset();
        test_add();
        test_load();
        test_branch();
        test_trap();
        test_illegal_r();
        test_uj();
        test_store_nohs();
        test_halt();
        test_rst_mid_wr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
